ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader_if.sv | 21 ++
 rtl/ccff_chain_loader.sv | 150 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between the host and the ccff chain loader.
// The host drives the word and valid, and the loader answers with ready.
interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (
      output cfg_data,
      output cfg_valid,
      input  cfg_ready
   );

   modport slave (
      input  cfg_data,
      input  cfg_valid,
      output cfg_ready
   );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serial loader for a configuration flip-flop (ccff) chain.
// Bitstream words arrive over a valid/ready handshake. Each word is shifted
// into the chain head LSB-first, with one chain shift per enabled prog_clk
// edge. The final word is trimmed so the chain receives exactly CHAIN_LEN bits.
// Optional feature macro: CCFF_READBACK_EN. When it is defined, a second pass
// (VERIFY) is added. In that pass the host resends the same stream, and every
// bit coming out of ccff_tail is compared with the bit going in at ccff_head.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 80,
   parameter int WORD_W    = 8
) (
   input  logic                prog_clk,
   input  logic                pReset,
   input  logic                start,
   ccff_chain_loader_if.slave  cfg,
   output logic                ccff_head,
   output logic                ccff_shift_en,
   input  logic                ccff_tail,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [15:0]         mismatch_cnt
);
   localparam int              CW          = $clog2(WORD_W + 1);
   localparam logic [15:0]     CHAIN_LEN_V = 16'(CHAIN_LEN);
   localparam logic [15:0]     WORD_W_V    = 16'(WORD_W);
   localparam logic [CW-1:0]   WORD_W_C    = CW'(WORD_W);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
`ifdef CCFF_READBACK_EN
      VERIFY = 2'd2,
`endif
      DONE   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WORD_W-1:0] sreg;
   logic [CW-1:0]     cnt;
   logic [15:0]       bits_left;
   logic              start_load;
   logic              handshake;
   logic              last_shift;

   // A new load may begin only while idle or finished.
   assign start_load = start && ((state == IDLE) || (state == DONE));
   assign handshake  = cfg.cfg_valid && cfg.cfg_ready;
   assign last_shift = ccff_shift_en && (bits_left == 16'd1);
   assign ccff_head  = sreg[0];

   // State register.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. The pass ends on the edge that performs the final shift.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (start) state_next = LOAD;
         end
         LOAD: begin
`ifdef CCFF_READBACK_EN
            if (last_shift) state_next = VERIFY;
`else
            if (last_shift) state_next = DONE;
`endif
         end
`ifdef CCFF_READBACK_EN
         VERIFY: begin
            if (last_shift) state_next = DONE;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // Output decode. Ready and shift enable come only from registered state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         LOAD:    busy = 1'b1;
`ifdef CCFF_READBACK_EN
         VERIFY:  busy = 1'b1;
`endif
         DONE:    done = 1'b1;
         default: ;
      endcase
      ccff_shift_en = busy && (cnt != '0);
      cfg.cfg_ready = busy && (cnt == '0) && (bits_left != '0);
   end

   // Shift register and bit counters.
   // Shift and word load never coincide, because ready requires cnt == 0.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         sreg      <= '0;
         cnt       <= '0;
         bits_left <= '0;
      end else if (start_load) begin
         cnt       <= '0;
         bits_left <= CHAIN_LEN_V;
      end else if (ccff_shift_en) begin
         sreg <= sreg >> 1;
         cnt  <= cnt - CW'(1);
`ifdef CCFF_READBACK_EN
         if (last_shift && (state == LOAD)) begin
            bits_left <= CHAIN_LEN_V;
         end else begin
            bits_left <= bits_left - 16'd1;
         end
`else
         bits_left <= bits_left - 16'd1;
`endif
      end else if (handshake) begin
         sreg <= cfg.cfg_data;
         // Only the low bits_left bits of a short final word reach the chain.
         cnt  <= (bits_left >= WORD_W_V) ? WORD_W_C : CW'(bits_left);
      end
   end

`ifdef CCFF_READBACK_EN
   // Readback check: compare the tail bit with the resent head bit on each shift.
   always_ff @(posedge prog_clk) begin
      if (pReset || start_load) begin
         err          <= 1'b0;
         mismatch_cnt <= '0;
      end else if ((state == VERIFY) && ccff_shift_en && (ccff_tail != ccff_head)) begin
         err <= 1'b1;
         if (mismatch_cnt != '1) begin
            mismatch_cnt <= mismatch_cnt + 16'd1;
         end
      end
   end
`else
   logic unused_tail;

   assign unused_tail  = ccff_tail;
   assign err          = 1'b0;
   assign mismatch_cnt = '0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader. It uses two instances, with chains of
// 80 and 20 flops, and each instance drives its own behavioural chain model.
module tb_ccff_chain_loader;
`ifdef CCFF_READBACK_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif

   logic        prog_clk = 1'b0;
   logic        pReset   = 1'b1;
   logic        start    = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [7:0]  cfg_data  = '0;
   logic        sel       = 1'b0;
   logic        flip_req  = 1'b0;
   logic        start80, start20;

   always #5 prog_clk = ~prog_clk;

   assign start80 = start & ~sel;
   assign start20 = start & sel;

   ccff_chain_loader_if #(.WORD_W(8)) bus80 ();
   ccff_chain_loader_if #(.WORD_W(8)) bus20 ();

   assign bus80.cfg_data  = cfg_data;
   assign bus80.cfg_valid = cfg_valid;
   assign bus20.cfg_data  = cfg_data;
   assign bus20.cfg_valid = cfg_valid;

   logic        head80, sh80, tail80, busy80, done80, err80;
   logic        head20, sh20, tail20, busy20, done20, err20;
   logic [15:0] mc80, mc20;

   ccff_chain_loader #(.CHAIN_LEN(80), .WORD_W(8)) dut80 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start80), .cfg(bus80.slave),
      .ccff_head(head80), .ccff_shift_en(sh80), .ccff_tail(tail80),
      .busy(busy80), .done(done80), .err(err80), .mismatch_cnt(mc80)
   );

   ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start20), .cfg(bus20.slave),
      .ccff_head(head20), .ccff_shift_en(sh20), .ccff_tail(tail20),
      .busy(busy20), .done(done20), .err(err20), .mismatch_cnt(mc20)
   );

   // Chain models. Head bits enter at the MSB, so after N shifts the first
   // bit sent sits at bit 0 (the tail) and chain[i] holds stream bit i.
   logic [79:0] chain80 = '0;
   logic [19:0] chain20 = '0;

   always @(posedge prog_clk) begin
      if (flip_req) chain80[19] <= ~chain80[19];
      else if (sh80) chain80 <= {head80, chain80[79:1]};
      if (sh20) chain20 <= {head20, chain20[19:1]};
   end

   assign tail80 = chain80[0];
   assign tail20 = chain20[0];

   // View of whichever instance is under test.
   logic        m_ready, m_shift, m_head, m_busy, m_done, m_err;
   logic [15:0] m_mc;
   logic [79:0] m_chain;

   always_comb begin
      if (sel) begin
         m_ready = bus20.cfg_ready; m_shift = sh20; m_head = head20;
         m_busy = busy20; m_done = done20; m_err = err20; m_mc = mc20;
         m_chain = {60'b0, chain20};
      end else begin
         m_ready = bus80.cfg_ready; m_shift = sh80; m_head = head80;
         m_busy = busy80; m_done = done80; m_err = err80; m_mc = mc80;
         m_chain = chain80;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   logic [79:0] cur_words;
   int          r_shifts, r_cycles, r_hs;
   bit          r_aborted, r_timeout;

   // Start a load on the selected instance and feed words until it leaves
   // busy. Optional events: a valid stall, a start pulse, a reset, and a
   // chain bit flip between the passes.
   task automatic run_load(input bit which, input int nwords, input int stall_at,
                           input int pulse_at, input int rst_at, input bit flip);
      int  k;
      int  stall_left;
      bit  stall_done;
      logic head_ref;
      k = 0; stall_left = 0; stall_done = 0; head_ref = 1'b0;
      r_shifts = 0; r_cycles = 0; r_hs = 0; r_aborted = 0; r_timeout = 0;
      @(negedge prog_clk);
      sel = which; start = 1'b1; cfg_valid = 1'b0;
      @(negedge prog_clk);
      start = 1'b0;
      while (1) begin
         flip_req = 1'b0;
         start    = 1'b0;
         if (!m_busy) break;
         if (r_cycles >= 400) begin
            r_timeout = 1;
            break;
         end
         r_cycles++;
         if (m_shift) r_shifts++;
         if (rst_at >= 0 && m_shift && r_shifts == rst_at) begin
            pReset = 1'b1;
            cfg_valid = 1'b0;
            @(negedge prog_clk);
            pReset = 1'b0;
            r_aborted = 1;
            break;
         end
         if (pulse_at >= 0 && m_shift && r_shifts == pulse_at) start = 1'b1;
         if (flip && m_ready && r_shifts == 80) flip_req = 1'b1;
         if (stall_at >= 0 && !stall_done && m_ready && r_shifts == stall_at) begin
            stall_left = 5; stall_done = 1; head_ref = m_head;
         end
         if (stall_left > 0) begin
            cfg_valid = 1'b0;
            check("stall_shift_en", 80'(m_shift), 80'(0));
            check("stall_head", 80'(m_head), 80'(head_ref));
            stall_left--;
         end else begin
            cfg_valid = 1'b1;
            cfg_data  = cur_words[8*(k % nwords) +: 8];
            if (m_ready) begin
               k++;
               r_hs++;
            end
         end
         @(negedge prog_clk);
      end
      cfg_valid = 1'b0;
   endtask

   typedef struct {
      bit          which;
      logic [79:0] words;
      int          nwords;
      int          stall_at;
      int          pulse_at;
      logic [79:0] exp_chain;
      int          exp_shifts;
      int          exp_cycles;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b0, 80'hA50FF0DEBC9A78563412, 10, -1, -1, 80'hA50FF0DEBC9A78563412, 80, 90};
      vecs[1] = '{1'b0, 80'h80017EE7C33CAA5500FF, 10, 16, -1, 80'h80017EE7C33CAA5500FF, 80, 90};
      vecs[2] = '{1'b0, 80'h0000FFFF123484215A5A, 10, -1, 40, 80'h0000FFFF123484215A5A, 80, 90};
      vecs[3] = '{1'b1, 80'hFF3CA5, 3, -1, -1, 80'hF3CA5, 20, 23};
      vecs[4] = '{1'b1, 80'h123456, 3, -1, -1, 80'h23456, 20, 23};
      vecs[5] = '{1'b1, 80'hABCDEF, 3, -1, -1, 80'hBCDEF, 20, 23};

      // Reset state of both instances.
      repeat (3) @(negedge prog_clk);
      pReset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_ready", 80'(m_ready), 80'(0));
         check("rst_shift_en", 80'(m_shift), 80'(0));
         check("rst_head", 80'(m_head), 80'(0));
         check("rst_busy", 80'(m_busy), 80'(0));
         check("rst_done", 80'(m_done), 80'(0));
         check("rst_err", 80'(m_err), 80'(0));
         check("rst_mismatch_cnt", 80'(m_mc), 80'(0));
      end

      // Table-driven loads.
      for (int i = 0; i < 6; i++) begin
         cur_words = vecs[i].words;
         run_load(vecs[i].which, vecs[i].nwords, vecs[i].stall_at, vecs[i].pulse_at, -1, 1'b0);
         check("timeout", 80'(r_timeout), 80'(0));
         check("shift_count", 80'(r_shifts), 80'(vecs[i].exp_shifts * PASSES));
         check("cycle_count", 80'(r_cycles),
               80'(vecs[i].exp_cycles * PASSES + ((vecs[i].stall_at >= 0) ? 5 : 0)));
         check("handshakes", 80'(r_hs), 80'(vecs[i].nwords * PASSES));
         check("chain", m_chain, vecs[i].exp_chain);
         check("done", 80'(m_done), 80'(1));
         check("ready_in_done", 80'(m_ready), 80'(0));
         check("err", 80'(m_err), 80'(0));
         check("mismatch_cnt", 80'(m_mc), 80'(0));
      end

      // Reset in the middle of a load, then a clean reload.
      cur_words = vecs[0].words;
      run_load(1'b0, 10, -1, -1, 37, 1'b0);
      check("abort_taken", 80'(r_aborted), 80'(1));
      check("abort_shifts", 80'(r_shifts), 80'(37));
      check("abort_ready", 80'(m_ready), 80'(0));
      check("abort_shift_en", 80'(m_shift), 80'(0));
      check("abort_head", 80'(m_head), 80'(0));
      check("abort_busy", 80'(m_busy), 80'(0));
      check("abort_done", 80'(m_done), 80'(0));
      for (int c = 0; c < 3; c++) begin
         cfg_valid = 1'b1;
         @(negedge prog_clk);
         check("idle_no_shift", 80'(m_shift), 80'(0));
      end
      cfg_valid = 1'b0;
      cur_words = vecs[1].words;
      run_load(1'b0, 10, -1, -1, -1, 1'b0);
      check("reload_shifts", 80'(r_shifts), 80'(80 * PASSES));
      check("reload_chain", m_chain, 80'h80017EE7C33CAA5500FF);
      check("reload_done", 80'(m_done), 80'(1));

`ifdef CCFF_READBACK_EN
      // Flip stream bit 19 (word 2, bit 3) in the chain between the passes.
      cur_words = vecs[0].words;
      run_load(1'b0, 10, -1, -1, -1, 1'b1);
      check("flip_shifts", 80'(r_shifts), 80'(160));
      check("flip_err", 80'(m_err), 80'(1));
      check("flip_mismatch_cnt", 80'(m_mc), 80'(1));
      check("flip_chain", m_chain, 80'hA50FF0DEBC9A78563412);
      check("flip_done", 80'(m_done), 80'(1));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
